fetch_stage: RTL and testbench

IF stage of the five-stage MIPS pipeline: owns the PC register, addresses instruction memory and loads the IF/ID pipeline register that feeds the decode stage.
- Honours the hazard-unit stall, decode-stage redirects (branch/jump/eret, delay-slot semantics) and the CP0 exception flush to the handler vector.
- Annotates each fetched instruction with a branch-delay flag and an exception code, which decode/CP0 use for EPC and BD.

---
 rtl/fetch_stage.sv | 101 ++++++++++
 tb/tb_fetch_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF stage: PC register, instruction-memory addressing and the IF/ID pipeline register.
// Define FETCH_ADEL_CHECK_EN to flag misaligned or out-of-range fetches as AdEL.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_TOP     = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_flush,
  input  logic        d_redirect,
  input  logic [31:0] d_npc,
  input  logic        d_is_ctrl,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] f_pc,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic        d_bd,
  output logic [4:0]  d_exc,
  output logic        d_valid
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

`ifdef FETCH_ADEL_CHECK_EN
  localparam logic ADEL_EN = 1'b1;
`else
  localparam logic ADEL_EN = 1'b0;
`endif

  logic [31:0] pc_q,    pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] dpc_q,   dpc_d;
  logic        bd_q,    bd_d;
  logic [4:0]  exc_q,   exc_d;
  logic        valid_q, valid_d;

  logic        addr_bad;
  logic [4:0]  fetch_exc;

  assign addr_bad  = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_TOP);
  assign fetch_exc = (ADEL_EN && addr_bad) ? EXC_ADEL : EXC_NONE;

  // NOTE: every next-state signal gets a hold default first, so no path leaves it unassigned (no latch).
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    dpc_d   = dpc_q;
    bd_d    = bd_q;
    exc_d   = exc_q;
    valid_d = valid_q;
    if (exc_flush) begin
      pc_d    = HANDLER_PC;
      instr_d = '0;
      dpc_d   = '0;
      bd_d    = 1'b0;
      exc_d   = EXC_NONE;
      valid_d = 1'b0;
    end else if (!stall) begin
      // A faulting fetch carries a nop so only the exception code travels on.
      instr_d = (fetch_exc != EXC_NONE) ? '0 : im_rdata;
      dpc_d   = pc_q;
      bd_d    = d_is_ctrl;
      exc_d   = fetch_exc;
      valid_d = 1'b1;
      pc_d    = d_redirect ? d_npc : pc_q + 32'd4;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      dpc_q   <= '0;
      bd_q    <= 1'b0;
      exc_q   <= EXC_NONE;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      dpc_q   <= dpc_d;
      bd_q    <= bd_d;
      exc_q   <= exc_d;
      valid_q <= valid_d;
    end
  end

  assign im_addr = pc_q;
  assign f_pc    = pc_q;
  assign d_instr = instr_q;
  assign d_pc    = dpc_q;
  assign d_bd    = bd_q;
  assign d_exc   = exc_q;
  assign d_valid = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by randomized
// control traffic, compared against a cycle-level behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_BASE    = 32'h0000_3000;
  localparam logic [31:0] IM_TOP     = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        exc_flush;
  logic        d_redirect;
  logic [31:0] d_npc;
  logic        d_is_ctrl;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic [31:0] f_pc;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic        d_bd;
  logic [4:0]  d_exc;
  logic        d_valid;

  int checks = 0;
  int errors = 0;

  // Expected architectural state
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  logic [31:0] exp_dpc;
  logic        exp_bd;
  logic [4:0]  exp_exc;
  logic        exp_valid;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .exc_flush  (exc_flush),
    .d_redirect (d_redirect),
    .d_npc      (d_npc),
    .d_is_ctrl  (d_is_ctrl),
    .im_addr    (im_addr),
    .im_rdata   (im_rdata),
    .f_pc       (f_pc),
    .d_instr    (d_instr),
    .d_pc       (d_pc),
    .d_bd       (d_bd),
    .d_exc      (d_exc),
    .d_valid    (d_valid)
  );

  always #5 clk = ~clk;

  // Instruction memory: an address-dependent pattern so each PC yields a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  assign im_rdata = mem_word(im_addr);

  function automatic int fetch_code(input logic [31:0] a);
`ifdef FETCH_ADEL_CHECK_EN
    if ((a % 4) != 0 || a < IM_BASE || a > IM_TOP) return 4;
`endif
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string when);
    check({when, ".f_pc"},    f_pc,              exp_pc);
    check({when, ".im_addr"}, im_addr,           exp_pc);
    check({when, ".d_instr"}, d_instr,           exp_instr);
    check({when, ".d_pc"},    d_pc,              exp_dpc);
    check({when, ".d_bd"},    {31'd0, d_bd},     {31'd0, exp_bd});
    check({when, ".d_exc"},   {27'd0, d_exc},    {27'd0, exp_exc});
    check({when, ".d_valid"}, {31'd0, d_valid},  {31'd0, exp_valid});
  endtask

  // One clock cycle: drive inputs mid-cycle, confirm nothing moves before the edge,
  // advance the model, then compare after the edge.
  task automatic step(input logic r, input logic s, input logic f, input logic rd,
                      input logic [31:0] npc, input logic c);
    int code;
    @(negedge clk);
    reset = r; stall = s; exc_flush = f; d_redirect = rd; d_npc = npc; d_is_ctrl = c;
    #1;
    check_outputs("pre");
    if (r) begin
      exp_pc = RESET_PC; exp_instr = 0; exp_dpc = 0; exp_bd = 0; exp_exc = 0; exp_valid = 0;
    end else if (f) begin
      exp_pc = HANDLER_PC; exp_instr = 0; exp_dpc = 0; exp_bd = 0; exp_exc = 0; exp_valid = 0;
    end else if (!s) begin
      code      = fetch_code(exp_pc);
      exp_instr = (code != 0) ? 32'd0 : mem_word(exp_pc);
      exp_dpc   = exp_pc;
      exp_bd    = c;
      exp_exc   = 5'(code);
      exp_valid = 1'b1;
      exp_pc    = rd ? npc : exp_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    check_outputs("post");
  endtask

  function automatic logic [31:0] rand_npc();
    logic [31:0] base;
    base = IM_BASE + ($urandom_range(0, 32'h0FFF) << 2);
    case ($urandom_range(0, 5))
      0, 1: return base;
      2:    return base + $urandom_range(1, 3);
      3:    return $urandom_range(0, 32'h2FFC) & ~32'd3;
      4:    return $urandom_range(0, 1) ? 32'hFFFF_FFFC : 32'h0000_7000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; stall = 1'b0; exc_flush = 1'b0; d_redirect = 1'b0; d_npc = '0; d_is_ctrl = 1'b0;
    // Values before any edge are unknown; the model is seeded by the first reset edge.
    @(posedge clk);
    #1;
    exp_pc = RESET_PC; exp_instr = 0; exp_dpc = 0; exp_bd = 0; exp_exc = 0; exp_valid = 0;
    check_outputs("reset");

    // 1: reset held, then sequential fetch
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("t1.d_pc", d_pc, 32'h0000_3000);
    check("t1.f_pc", f_pc, 32'h0000_3004);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // 2: taken branch at f_pc=0x3010, delay slot then target
    check("t2.pre_pc", f_pc, 32'h0000_3010);
    step(0, 0, 0, 1, 32'h0000_3100, 1);
    check("t2.slot_bd", {31'd0, d_bd}, 32'd1);
    check("t2.target", f_pc, 32'h0000_3100);
    step(0, 0, 0, 0, 0, 0);
    check("t2.target_d", d_pc, 32'h0000_3100);

    // 3: redirect held under stall for 3 cycles, taken once stall drops
    repeat (3) step(0, 1, 0, 1, 32'h0000_3200, 1);
    step(0, 0, 0, 1, 32'h0000_3200, 1);
    check("t3.redirect", f_pc, 32'h0000_3200);

    // 4: flush wins over stall at f_pc=0x3040
    step(0, 0, 0, 1, 32'h0000_3040, 1);
    step(0, 1, 1, 0, 0, 0);
    check("t4.handler", f_pc, HANDLER_PC);
    step(0, 0, 0, 0, 0, 0);
    check("t4.handler_d", d_pc, HANDLER_PC);

    // 5: misaligned and out-of-range targets
    step(0, 0, 0, 1, 32'h0000_3002, 1);
    step(0, 0, 0, 1, 32'h0000_7000, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    // 6: reset during stall+redirect
    step(0, 1, 0, 1, 32'h0000_5000, 1);
    step(1, 1, 0, 1, 32'h0000_5000, 1);
    step(0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic r, s, f, rd, c;
      r  = ($urandom_range(0, 63) == 0);
      f  = ($urandom_range(0, 15) == 0);
      s  = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 2) == 0);
      c  = rd | ($urandom_range(0, 5) == 0);
      step(r, s, f, rd, rand_npc(), c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
